// File: rtl/mem_wb_stage.sv
//------------------------------------------------------------------------------
// Module : mem_wb_stage
// Brief  : MEM/WB pipeline register and load write-back formatter for the
//          regfile write port. Optional HI/LO carry enabled by MEM_WB_HILO_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               stall_mem,
  input  logic               stall_wb,
  input  logic               mem_wreg,
  input  logic [RADDR_W-1:0] mem_wd,
  input  logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_load,
  input  logic [2:0]         mem_ltype,
  input  logic [1:0]         mem_addr_lo,
  input  logic [DATA_W-1:0]  ram_rdata,
`ifdef MEM_WB_HILO_EN
  input  logic               mem_whilo,
  input  logic [DATA_W-1:0]  mem_hi,
  input  logic [DATA_W-1:0]  mem_lo,
  output logic               wb_whilo,
  output logic [DATA_W-1:0]  wb_hi,
  output logic [DATA_W-1:0]  wb_lo,
`endif
  output logic               wb_we,
  output logic [RADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0]  wb_wdata
);

  localparam logic [2:0] c_lb  = 3'd0;
  localparam logic [2:0] c_lbu = 3'd1;
  localparam logic [2:0] c_lh  = 3'd2;
  localparam logic [2:0] c_lhu = 3'd3;

  logic               r_wreg;
  logic [RADDR_W-1:0] r_wd;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_load;
  logic [2:0]         r_ltype;
  logic [1:0]         r_addr_lo;
  logic [DATA_W-1:0]  r_hold;
  logic               r_hold_vld;

  logic               w_bubble;
  logic [DATA_W-1:0]  w_raw;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [DATA_W-1:0]  w_load_data;

  assign w_bubble = flush | (stall_mem & ~stall_wb);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wreg     <= 1'b0;
      r_wd       <= '0;
      r_wdata    <= '0;
      r_load     <= 1'b0;
      r_ltype    <= '0;
      r_addr_lo  <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
    end else if (w_bubble) begin
      r_wreg     <= 1'b0;
      r_wd       <= '0;
      r_wdata    <= '0;
      r_load     <= 1'b0;
      r_ltype    <= '0;
      r_addr_lo  <= '0;
      r_hold_vld <= 1'b0;
    end else if (stall_wb) begin
      // The RAM output is only valid on the first WB cycle; freeze it there.
      if (r_load && !r_hold_vld) begin
        r_hold     <= ram_rdata;
        r_hold_vld <= 1'b1;
      end
    end else begin
      r_wreg     <= mem_wreg;
      r_wd       <= mem_wd;
      r_wdata    <= mem_wdata;
      r_load     <= mem_load;
      r_ltype    <= mem_ltype;
      r_addr_lo  <= mem_addr_lo;
      r_hold_vld <= 1'b0;
    end
  end

  always_comb begin
    w_raw  = r_hold_vld ? r_hold : ram_rdata;
    w_byte = 8'h00;
    case (r_addr_lo)
      2'd0:    w_byte = w_raw[31:24];
      2'd1:    w_byte = w_raw[23:16];
      2'd2:    w_byte = w_raw[15:8];
      default: w_byte = w_raw[7:0];
    endcase
    w_half      = r_addr_lo[1] ? w_raw[15:0] : w_raw[31:16];
    w_load_data = '0;
    case (r_ltype)
      c_lb:  w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
      c_lbu: w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
      c_lh:  w_load_data = r_addr_lo[0] ? '0 : {{(DATA_W-16){w_half[15]}}, w_half};
      c_lhu: w_load_data = r_addr_lo[0] ? '0 : {{(DATA_W-16){1'b0}}, w_half};
      default: w_load_data = (r_addr_lo == 2'd0) ? w_raw : '0;
    endcase
  end

  assign wb_we    = r_wreg;
  assign wb_waddr = r_wd;
  assign wb_wdata = r_load ? w_load_data : r_wdata;

`ifdef MEM_WB_HILO_EN
  logic              r_whilo;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (w_bubble) begin
      r_whilo <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (!stall_wb) begin
      r_whilo <= mem_whilo;
      r_hi    <= mem_hi;
      r_lo    <= mem_lo;
    end
  end

  assign wb_whilo = r_whilo;
  assign wb_hi    = r_hi;
  assign wb_lo    = r_lo;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
//------------------------------------------------------------------------------
// Module : tb_mem_wb_stage
// Brief  : Self-checking bench for mem_wb_stage: directed cases plus random
//          traffic against a slot-level model. Honours MEM_WB_HILO_EN.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, stall_mem, stall_wb;
  logic        mem_wreg, mem_load;
  logic [4:0]  mem_wd;
  logic [31:0] mem_wdata, ram_rdata;
  logic [2:0]  mem_ltype;
  logic [1:0]  mem_addr_lo;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
`ifdef MEM_WB_HILO_EN
  logic        mem_whilo, wb_whilo;
  logic [31:0] mem_hi, mem_lo, wb_hi, wb_lo;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem_wreg(mem_wreg), .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_load(mem_load),
    .mem_ltype(mem_ltype), .mem_addr_lo(mem_addr_lo), .ram_rdata(ram_rdata),
`ifdef MEM_WB_HILO_EN
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
`endif
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  // One instruction occupying the WB slot, plus the load value frozen by a WB stall.
  typedef struct {
    bit          wreg;
    bit [4:0]    wd;
    bit [31:0]   wdata;
    bit          load;
    bit [2:0]    ltype;
    bit [1:0]    lo;
    bit          frozen;
    bit [31:0]   fval;
    bit          whilo;
    bit [31:0]   hi;
    bit [31:0]   lo_val;
  } slot_t;

  slot_t m;

  function automatic slot_t empty_slot();
    slot_t s;
    s.wreg = 0; s.wd = 0; s.wdata = 0; s.load = 0; s.ltype = 0; s.lo = 0;
    s.frozen = 0; s.fval = 0; s.whilo = 0; s.hi = 0; s.lo_val = 0;
    return s;
  endfunction

  // Load formatting from byte-lane arithmetic (big-endian: lane 0 is the MSB byte).
  function automatic bit [31:0] fmt(bit [2:0] t, bit [1:0] lo, bit [31:0] raw);
    bit [31:0] b, h;
    b = (raw >> (8 * (3 - lo))) & 32'hFF;
    h = (raw >> (16 * (1 - lo / 2))) & 32'hFFFF;
    case (t)
      3'd0: return (b >= 128) ? b - 256 : b;
      3'd1: return b;
      3'd2: return (lo % 2 != 0) ? 0 : ((h >= 32768) ? h - 65536 : h);
      3'd3: return (lo % 2 != 0) ? 0 : h;
      default: return (lo == 0) ? raw : 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m = empty_slot();
    end else if (flush || (stall_mem && !stall_wb)) begin
      m = empty_slot();
    end else if (stall_wb) begin
      if (m.load && !m.frozen) begin
        m.frozen = 1; m.fval = ram_rdata;
      end
    end else begin
      m = empty_slot();
      m.wreg = mem_wreg; m.wd = mem_wd; m.wdata = mem_wdata; m.load = mem_load;
      m.ltype = mem_ltype; m.lo = mem_addr_lo;
`ifdef MEM_WB_HILO_EN
      m.whilo = mem_whilo; m.hi = mem_hi; m.lo_val = mem_lo;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_we",    {31'd0, wb_we}, {31'd0, m.wreg});
      check("model_waddr", {27'd0, wb_waddr}, {27'd0, m.wd});
      check("model_wdata", wb_wdata, m.load ? fmt(m.ltype, m.lo, m.frozen ? m.fval : ram_rdata) : m.wdata);
`ifdef MEM_WB_HILO_EN
      check("model_whilo", {31'd0, wb_whilo}, {31'd0, m.whilo});
      check("model_hi", wb_hi, m.hi);
      check("model_lo", wb_lo, m.lo_val);
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    flush = 0; stall_mem = 0; stall_wb = 0; mem_wreg = 0; mem_wd = 0; mem_wdata = 0;
    mem_load = 0; mem_ltype = 0; mem_addr_lo = 0;
`ifdef MEM_WB_HILO_EN
    mem_whilo = 0; mem_hi = 0; mem_lo = 0;
`endif
  endtask

  task automatic drive_load(input bit [4:0] wd, input bit [2:0] t, input bit [1:0] lo);
    idle_in();
    mem_wreg = 1; mem_wd = wd; mem_load = 1; mem_ltype = t; mem_addr_lo = lo;
    mem_wdata = 32'h5555_AAAA;
  endtask

  initial begin
    rst = 0; ram_rdata = 0; idle_in();
    #7;
    check("reset_we",    {31'd0, wb_we}, 32'd0);
    check("reset_waddr", {27'd0, wb_waddr}, 32'd0);
    check("reset_wdata", wb_wdata, 32'd0);
    rst = 1;
    chk_en = 1;
    step();

    // ALU pass-through
    idle_in(); mem_wreg = 1; mem_wd = 5; mem_wdata = 32'h1234_5678;
    step(); idle_in();
    @(negedge clk);
    check("alu_we", {31'd0, wb_we}, 32'd1);
    check("alu_waddr", {27'd0, wb_waddr}, 32'd5);
    check("alu_wdata", wb_wdata, 32'h1234_5678);

    // LB then LBU at addr_lo 01
    drive_load(3, 3'd0, 2'd1); step();
    ram_rdata = 32'h0080_0000; drive_load(3, 3'd1, 2'd1);
    @(negedge clk); check("lb_sext", wb_wdata, 32'hFFFF_FF80);
    step(); ram_rdata = 32'h0080_0000; idle_in();
    @(negedge clk); check("lbu_zext", wb_wdata, 32'h0000_0080);

    // LH aligned and misaligned
    drive_load(4, 3'd2, 2'd2); step();
    ram_rdata = 32'h0000_8001; drive_load(4, 3'd2, 2'd1);
    @(negedge clk); check("lh_lo_half", wb_wdata, 32'hFFFF_8001);
    step(); idle_in();
    @(negedge clk); check("lh_misalign", wb_wdata, 32'h0000_0000);

    // LW held across a three-cycle WB stall while RAM output changes
    drive_load(6, 3'd4, 2'd0); step();
    idle_in(); stall_wb = 1; ram_rdata = 32'hCAFE_F00D;
    @(negedge clk); check("lw_stall_c1", wb_wdata, 32'hCAFE_F00D);
    step(); ram_rdata = 32'h0000_DEAD;
    @(negedge clk); check("lw_stall_c2", wb_wdata, 32'hCAFE_F00D);
    step(); ram_rdata = 32'h0000_DEAD;
    @(negedge clk); check("lw_stall_c3", wb_wdata, 32'hCAFE_F00D);
    check("lw_stall_we", {31'd0, wb_we}, 32'd1);
    stall_wb = 0; step();

    // stall_mem bubble, then flush beating stall_wb
    idle_in(); mem_wreg = 1; mem_wd = 7; stall_mem = 1; step();
    idle_in(); @(negedge clk); check("stall_mem_bubble", {31'd0, wb_we}, 32'd0);
    mem_wreg = 1; mem_wd = 9; mem_wdata = 32'h99; step();
    idle_in(); flush = 1; stall_wb = 1;
    @(negedge clk); check("pre_flush_we", {31'd0, wb_we}, 32'd1);
    step(); idle_in();
    @(negedge clk); check("flush_over_stall", {31'd0, wb_we}, 32'd0);

    // asynchronous reset between edges
    mem_wreg = 1; mem_wd = 10; mem_wdata = 32'hAA; step(); idle_in();
    @(negedge clk); check("pre_rst_we", {31'd0, wb_we}, 32'd1);
    #2 rst = 0;
    #1;
    check("async_rst_we", {31'd0, wb_we}, 32'd0);
    check("async_rst_wdata", wb_wdata, 32'd0);
    check("async_rst_waddr", {27'd0, wb_waddr}, 32'd0);
    step(); rst = 1;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      rst         = ($urandom_range(0, 199) != 0);
      flush       = ($urandom_range(0, 9) == 0);
      stall_mem   = ($urandom_range(0, 5) == 0);
      stall_wb    = ($urandom_range(0, 3) == 0);
      mem_wreg    = $urandom_range(0, 1);
      mem_wd      = 5'($urandom);
      mem_wdata   = $urandom;
      mem_load    = $urandom_range(0, 1);
      mem_ltype   = 3'($urandom);
      mem_addr_lo = 2'($urandom);
      ram_rdata   = $urandom;
`ifdef MEM_WB_HILO_EN
      mem_whilo   = $urandom_range(0, 1);
      mem_hi      = $urandom;
      mem_lo      = $urandom;
`endif
    end
    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
